apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester (initiator) that converts a simple valid/ready command stream into APB setup/access transfers.
- Returns one response per command: read data, slave error, timeout.
- Sits between an internal controller or bus bridge and the team's APB peripherals (e.g. the APB RAM slave).
- Issues one transfer at a time, with a bounded wait on pready.

Parameters:
- ADDR_W, 32, width of paddr and cmd_addr.
- DATA_W, 32, width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_slverr  out  1  slave error or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset (presetn=0 at an edge):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout and the wait counter all go to 0.
  - Reset overrides every other event.
- Outputs: all APB and rsp outputs are registered. cmd_ready is combinational: (state==IDLE).
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - psel=0, penable=0.
  - On cmd_valid and cmd_ready at edge E0: register pwrite, paddr and pwdata from the cmd fields, set psel=1 (penable=0), go to SETUP.
- SETUP:
  - Lasts exactly one cycle. At E1, set penable=1, clear the wait counter, go to ACCESS.
  - paddr, pwrite, pwdata and psel are stable from E0 until the transfer ends.
- ACCESS, first matching rule applies at each edge:
  - pready=1: psel=0, penable=0, rsp_valid=1, rsp_slverr=pslverr, rsp_timeout=0, rsp_rdata=(pwrite ? 0 : prdata). Go to RESP.
  - TIMEOUT!=0, pready=0 and counter==TIMEOUT-1: psel=0, penable=0, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
  - Otherwise: counter+1; stay in ACCESS.
  - pready=1 on the same edge as the counter limit counts as a normal completion, not a timeout.
- RESP:
  - rsp_* held stable while rsp_ready=0.
  - On rsp_ready at an edge: rsp_valid=0, go to IDLE.
  - A new command is accepted only from IDLE, which guarantees at least one psel=0 cycle between transfers.
- After a transfer: paddr, pwdata and pwrite hold their last values; psel=0 and penable=0 outside SETUP/ACCESS.
- Latency:
  - With zero-wait slave and rsp_ready=1: command accepted at E0, psel visible after E0, penable after E1, pready sampled at E2, rsp_valid visible after E2, response consumed at E3.
  - Minimum issue rate: one transfer per 4 cycles.
  - Each slave wait state adds 1 cycle.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit.
- pslverr is sampled only when pready=1.
- Reset mid-transfer: bus is released at that edge; no response is produced for the in-flight command.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}.
  - packed struct apb_rsp_t {rdata, slverr, timeout}.
  - Default width constants APB_ADDR_W=32, APB_DATA_W=32.
- No sub-module: the wait counter and FSM stay in one always block plus the cmd_ready assign.

Test Plan:
- Write, zero-wait: write addr=0x04, data=0xDEADBEEF; slave holds pready=1.
  -> psel high 2 cycles, penable high 1 cycle, pwdata=0xDEADBEEF; rsp_valid 2 edges after accept; slverr=0, rdata=0.
- Read, 2 wait states: read addr=0x04; slave returns pready after 2 ACCESS cycles with prdata=0xDEADBEEF.
  -> penable high 3 cycles; rsp_rdata=0xDEADBEEF, rsp_slverr=0.
- Slave error: read addr=0x40; slave returns pready=1, pslverr=1.
  -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout, TIMEOUT=16: pready held 0.
  -> psel/penable drop after exactly 16 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  -> pready=1 on the 16th cycle instead gives a normal completion.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid held high.
  -> rsp fields stable, cmd_ready=0, psel=0 throughout; next command accepted the cycle after rsp_ready.
- Reset mid-transfer: presetn=0 during ACCESS.
  -> next edge: psel=penable=rsp_valid=0, state IDLE; a following write to 0x08 completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the APB requester and its peers.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: one valid/ready command in, one SETUP/ACCESS transfer out,
// one response back (read data, slave error, or timeout).
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  apb_mst_state_e    state_q;
  logic [CW-1:0]     cnt_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign cmd_ready = (state_q == IDLE);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over the timeout limit when both land on the same edge
          if (pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            state_q       <= RESP;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LIM) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction timeline model predicts every
// cycle of bus and response activity from wait-state and backpressure counts.
module tb_apb_master;

  localparam int TMO   = 16;
  localparam int NMAIN = 40;
  localparam int NT    = NMAIN + 1;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // transaction plan
  logic        p_wr  [NT];
  logic [31:0] p_addr[NT];
  logic [31:0] p_wd  [NT];
  logic [31:0] p_rd  [NT];
  logic        p_err [NT];
  int          p_w   [NT];
  int          p_r   [NT];
  int          p_g   [NT];

  // per-cycle expectations
  logic        chk_en = 1'b0;
  logic        e_cr, e_psel, e_pen, e_rv;
  logic        e_wr;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic        e_slverr, e_to;

  // observations for literal checks
  int          psel_cnt, pen_cnt, rv_cnt;
  logic [31:0] cap_rdata;
  logic        cap_slverr, cap_to;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(e_cr));
      chk("psel", 64'(psel), 64'(e_psel));
      chk("penable", 64'(penable), 64'(e_pen));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      if (e_psel) begin
        chk("pwrite", 64'(pwrite), 64'(e_wr));
        chk("paddr", 64'(paddr), 64'(e_addr));
        chk("pwdata", 64'(pwdata), 64'(e_wd));
      end
      if (e_rv) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
        chk("rsp_slverr", 64'(rsp_slverr), 64'(e_slverr));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
      end
      if (psel) psel_cnt++;
      if (penable) pen_cnt++;
      if (rsp_valid) begin
        rv_cnt++;
        cap_rdata  = rsp_rdata;
        cap_slverr = rsp_slverr;
        cap_to     = rsp_timeout;
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic exp_idle();
    e_cr = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
  endtask

  task automatic present(input int i);
    cmd_valid = 1'b1;
    cmd_write = p_wr[i];
    cmd_addr  = p_addr[i];
    cmd_wdata = p_wd[i];
  endtask

  task automatic quiet_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic run_txn(input int i);
    int  k, w, r;
    logic tmo;
    bit   nxt;
    w   = p_w[i];
    r   = p_r[i];
    tmo = (TMO != 0) && (w >= TMO);
    k   = tmo ? TMO : w + 1;
    nxt = (i + 1 < NMAIN) && (p_g[i + 1] == 0);
    psel_cnt = 0; pen_cnt = 0; rv_cnt = 0;
    for (int c = 0; c < p_g[i]; c++) begin
      quiet_cmd();
      exp_idle();
      step();
    end
    present(i);
    exp_idle();
    step();
    e_wr     = p_wr[i];
    e_addr   = p_addr[i];
    e_wd     = p_wd[i];
    e_rdata  = (tmo || p_wr[i]) ? 32'h0 : p_rd[i];
    e_slverr = tmo ? 1'b1 : p_err[i];
    e_to     = tmo;
    for (int j = 0; j <= k + 1 + r; j++) begin
      if (nxt) present(i + 1); else quiet_cmd();
      pready    = (j >= 1) && (j <= k) && (j == w + 1);
      prdata    = pready ? p_rd[i] : $urandom;
      pslverr   = pready ? p_err[i] : 1'($urandom);
      rsp_ready = (j == k + 1 + r) ? 1'b1 : ((j <= k) ? 1'($urandom) : 1'b0);
      e_cr   = 1'b0;
      e_psel = (j <= k);
      e_pen  = (j >= 1) && (j <= k);
      e_rv   = (j >= k + 1);
      step();
    end
    pready = 1'b0; rsp_ready = 1'b0;
    exp_idle();
  endtask

  initial begin
    presetn = 1'b0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    quiet_cmd();

    // directed entries, then random ones
    for (int i = 0; i < NT; i++) begin
      p_wr[i] = 1'($urandom); p_addr[i] = $urandom & 32'hFFFC; p_wd[i] = $urandom;
      p_rd[i] = $urandom; p_err[i] = ($urandom_range(0, 4) == 0);
      p_w[i] = $urandom_range(0, 20); p_r[i] = $urandom_range(0, 4); p_g[i] = $urandom_range(0, 2);
    end
    p_wr[0] = 1; p_addr[0] = 32'h04; p_wd[0] = 32'hDEADBEEF; p_err[0] = 0; p_w[0] = 0;  p_r[0] = 0; p_g[0] = 1;
    p_wr[1] = 0; p_addr[1] = 32'h04; p_rd[1] = 32'hDEADBEEF; p_err[1] = 0; p_w[1] = 2;  p_r[1] = 0;
    p_wr[2] = 0; p_addr[2] = 32'h40; p_rd[2] = 32'h12345678; p_err[2] = 1; p_w[2] = 0;
    p_wr[3] = 0; p_addr[3] = 32'h44; p_w[3] = 30;
    p_wr[4] = 0; p_addr[4] = 32'h48; p_rd[4] = 32'hCAFEF00D; p_err[4] = 0; p_w[4] = 15;
    p_wr[5] = 1; p_w[5] = 0; p_r[5] = 5;
    p_g[6]  = 0;
    p_wr[NMAIN] = 1; p_addr[NMAIN] = 32'h08; p_wd[NMAIN] = 32'h0BADF00D;
    p_w[NMAIN] = 1; p_r[NMAIN] = 1; p_g[NMAIN] = 1; p_err[NMAIN] = 0;

    step(); step();
    @(negedge pclk);
    chk("rst psel", 64'(psel), 64'd0);
    chk("rst penable", 64'(penable), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst paddr", 64'(paddr), 64'd0);
    chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
    step();
    presetn = 1'b1;
    exp_idle();
    chk_en = 1'b1;

    for (int i = 0; i < NMAIN; i++) begin
      run_txn(i);
      case (i)
        0: begin
          chk("t0 psel cycles", 64'(psel_cnt), 64'd2);
          chk("t0 penable cycles", 64'(pen_cnt), 64'd1);
          chk("t0 rdata", 64'(cap_rdata), 64'd0);
          chk("t0 slverr", 64'(cap_slverr), 64'd0);
        end
        1: begin
          chk("t1 penable cycles", 64'(pen_cnt), 64'd3);
          chk("t1 rdata", 64'(cap_rdata), 64'hDEADBEEF);
        end
        2: begin
          chk("t2 slverr", 64'(cap_slverr), 64'd1);
          chk("t2 timeout", 64'(cap_to), 64'd0);
          chk("t2 rdata", 64'(cap_rdata), 64'h12345678);
        end
        3: begin
          chk("t3 penable cycles", 64'(pen_cnt), 64'd16);
          chk("t3 timeout", 64'(cap_to), 64'd1);
          chk("t3 slverr", 64'(cap_slverr), 64'd1);
          chk("t3 rdata", 64'(cap_rdata), 64'd0);
        end
        4: begin
          chk("t4 penable cycles", 64'(pen_cnt), 64'd16);
          chk("t4 timeout", 64'(cap_to), 64'd0);
          chk("t4 rdata", 64'(cap_rdata), 64'hCAFEF00D);
        end
        5: chk("t5 rsp_valid cycles", 64'(rv_cnt), 64'd6);
        default: ;
      endcase
    end

    // reset in the middle of an ACCESS phase
    chk_en = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    step();
    quiet_cmd();
    step(); step(); step();
    @(negedge pclk);
    chk("pre-rst penable", 64'(penable), 64'd1);
    presetn = 1'b0;
    step();
    presetn = 1'b1;
    @(negedge pclk);
    chk("midrst psel", 64'(psel), 64'd0);
    chk("midrst penable", 64'(penable), 64'd0);
    chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    exp_idle();
    chk_en = 1'b1;
    run_txn(NMAIN);
    chk("post-rst penable cycles", 64'(pen_cnt), 64'd2);
    chk("post-rst rsp cycles", 64'(rv_cnt), 64'd2);
    step(); step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
